// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory address/data, redirect request and the
// valid/ready hand-off to decode.
interface fetch_unit_if;
  logic [15:0] pc;
  logic [15:0] instruction;
  logic        redirect_valid;
  logic [15:0] redirect_target;
  logic        ir_valid;
  logic        ir_ready;
  logic [15:0] ir_instr;
  logic [15:0] ir_pc;

  modport master (
    output pc, ir_valid, ir_instr, ir_pc,
    input  instruction, redirect_valid, redirect_target, ir_ready
  );

  modport slave (
    input  pc, ir_valid, ir_instr, ir_pc,
    output instruction, redirect_valid, redirect_target, ir_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns pc, captures imem words into a tagged IR for decode.
// Optional feature macro ALIGN_FAULT_EN: misaligned redirect traps into FAULT.
//
// state  | meaning
// IDLE   | out of reset, waiting for start
// RUN    | fetching one word per cycle when IR is empty or draining
// HALTED | zero word seen, pc frozen, waiting for start
// FAULT  | misaligned redirect seen, exits only by reset (ALIGN_FAULT_EN)
module fetch_unit #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter bit          HALT_ON_ZERO = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  fetch_unit_if.master bus,
  output logic         halted,
  output logic         fault,
  output logic [15:0]  fetch_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
`ifdef ALIGN_FAULT_EN
    ,FAULT = 2'd3
`endif
  } state_t;

  localparam logic [15:0] START_PC = RESET_VECTOR & 16'hFFFE;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        ir_valid_q, ir_valid_d;
  logic [15:0] ir_instr_q, ir_instr_d;
  logic [15:0] ir_pc_q, ir_pc_d;
  logic [15:0] cnt_q, cnt_d;

  logic advance;
  logic transfer;

  assign advance  = !ir_valid_q || bus.ir_ready;
  assign transfer = ir_valid_q && bus.ir_ready;

`ifndef ALIGN_FAULT_EN
  logic unused_tgt_lsb;
  assign unused_tgt_lsb = bus.redirect_target[0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= START_PC;
      ir_valid_q <= 1'b0;
      ir_instr_q <= 16'h0000;
      ir_pc_q    <= 16'h0000;
      cnt_q      <= 16'h0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_valid_q <= ir_valid_d;
      ir_instr_q <= ir_instr_d;
      ir_pc_q    <= ir_pc_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_valid_d = ir_valid_q;
    ir_instr_d = ir_instr_q;
    ir_pc_d    = ir_pc_q;
    cnt_d      = cnt_q;

    // Delivered-word count saturates rather than wrapping.
    if (transfer && (cnt_q != 16'hFFFF))
      cnt_d = cnt_q + 16'd1;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = START_PC;
        end
      end

      RUN: begin
        if (bus.redirect_valid) begin
          ir_valid_d = 1'b0;
`ifdef ALIGN_FAULT_EN
          if (bus.redirect_target[0])
            state_d = FAULT;
          else
            pc_d = bus.redirect_target;
`else
          pc_d = {bus.redirect_target[15:1], 1'b0};
`endif
        end else if (advance && HALT_ON_ZERO && (bus.instruction == 16'h0000)) begin
          // pc stays on the zero word so a debugger can see where fetch stopped.
          state_d = HALTED;
          if (bus.ir_ready)
            ir_valid_d = 1'b0;
        end else if (advance) begin
          ir_instr_d = bus.instruction;
          ir_pc_d    = pc_q;
          ir_valid_d = 1'b1;
          pc_d       = pc_q + 16'd2;
        end
      end

      HALTED: begin
        if (start) begin
          state_d    = RUN;
          pc_d       = START_PC;
          ir_valid_d = 1'b0;
        end else if (bus.ir_ready) begin
          ir_valid_d = 1'b0;
        end
      end

`ifdef ALIGN_FAULT_EN
      FAULT: begin
        ir_valid_d = 1'b0;
      end
`endif

      default: begin
        state_d    = IDLE;
        ir_valid_d = 1'b0;
      end
    endcase
  end

  assign bus.pc       = pc_q;
  assign bus.ir_valid = ir_valid_q;
  assign bus.ir_instr = ir_instr_q;
  assign bus.ir_pc    = ir_pc_q;
  assign halted       = (state_q == HALTED);
  assign fetch_count  = cnt_q;
`ifdef ALIGN_FAULT_EN
  assign fault        = (state_q == FAULT);
`else
  assign fault        = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a table of per-cycle vectors plus hand-written
// sequences for reset-in-flight, pc wrap with HALT_ON_ZERO=0, and misaligned redirect.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        rv;
  logic [15:0] rt;
  logic        rdy;

  logic        m_halted, m_fault;
  logic [15:0] m_cnt;
  logic        z_halted, z_fault;
  logic [15:0] z_cnt;

  logic [15:0] rom [0:127];

  int n_cmp = 0;
  int n_bad = 0;

  fetch_unit_if m_if ();
  fetch_unit_if z_if ();

  assign m_if.instruction     = rom[m_if.pc[7:1]];
  assign m_if.redirect_valid  = rv;
  assign m_if.redirect_target = rt;
  assign m_if.ir_ready        = rdy;
  assign z_if.instruction     = rom[z_if.pc[7:1]];
  assign z_if.redirect_valid  = rv;
  assign z_if.redirect_target = rt;
  assign z_if.ir_ready        = rdy;

  fetch_unit u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .bus         (m_if.master),
    .halted      (m_halted),
    .fault       (m_fault),
    .fetch_count (m_cnt)
  );

  fetch_unit #(.RESET_VECTOR(16'h0000), .HALT_ON_ZERO(1'b0)) u_dut_nz (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .bus         (z_if.master),
    .halted      (z_halted),
    .fault       (z_fault),
    .fetch_count (z_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        rv;
    logic [15:0] rt;
    logic        rdy;
    logic        ev;
    logic [15:0] epc;
    logic [15:0] eirpc;
    logic [15:0] einstr;
    logic        eh;
    logic [15:0] ecnt;
  } vec_t;

  vec_t vecs [22];

  function automatic vec_t mk(logic s, logic v, logic [15:0] t, logic r, logic ev,
                              logic [15:0] epc, logic [15:0] eirpc, logic [15:0] einstr,
                              logic eh, logic [15:0] ecnt);
    vec_t x;
    x.start = s; x.rv = v; x.rt = t; x.rdy = r; x.ev = ev; x.epc = epc;
    x.eirpc = eirpc; x.einstr = einstr; x.eh = eh; x.ecnt = ecnt;
    return x;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic v, input logic [15:0] t, input logic r);
    start = s; rv = v; rt = t; rdy = r;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 16'h1000 | 16'(i);
    rom[3] = 16'h0000;  // word at address 6 is the halt marker

    //           start rv rt        rdy   ev  pc        ir_pc     ir_instr  h   cnt
    vecs[0]  = mk(1, 0, 16'h0000, 1,    0, 16'h0000, 16'h0000, 16'h0000, 0, 16'd0);
    vecs[1]  = mk(0, 0, 16'h0000, 1,    1, 16'h0002, 16'h0000, 16'h1000, 0, 16'd0);
    vecs[2]  = mk(0, 0, 16'h0000, 1,    1, 16'h0004, 16'h0002, 16'h1001, 0, 16'd1);
    vecs[3]  = mk(0, 0, 16'h0000, 1,    1, 16'h0006, 16'h0004, 16'h1002, 0, 16'd2);
    vecs[4]  = mk(0, 0, 16'h0000, 1,    0, 16'h0006, 16'h0000, 16'h0000, 1, 16'd3);
    vecs[5]  = mk(0, 1, 16'h0040, 1,    0, 16'h0006, 16'h0000, 16'h0000, 1, 16'd3);
    vecs[6]  = mk(1, 0, 16'h0000, 0,    0, 16'h0000, 16'h0000, 16'h0000, 0, 16'd3);
    vecs[7]  = mk(0, 0, 16'h0000, 0,    1, 16'h0002, 16'h0000, 16'h1000, 0, 16'd3);
    vecs[8]  = mk(0, 0, 16'h0000, 0,    1, 16'h0002, 16'h0000, 16'h1000, 0, 16'd3);
    vecs[9]  = mk(0, 0, 16'h0000, 0,    1, 16'h0002, 16'h0000, 16'h1000, 0, 16'd3);
    vecs[10] = mk(0, 0, 16'h0000, 0,    1, 16'h0002, 16'h0000, 16'h1000, 0, 16'd3);
    vecs[11] = mk(0, 0, 16'h0000, 1,    1, 16'h0004, 16'h0002, 16'h1001, 0, 16'd4);
    vecs[12] = mk(0, 1, 16'h0010, 0,    0, 16'h0010, 16'h0000, 16'h0000, 0, 16'd4);
    vecs[13] = mk(0, 0, 16'h0000, 0,    1, 16'h0012, 16'h0010, 16'h1008, 0, 16'd4);
    vecs[14] = mk(0, 1, 16'h0020, 1,    0, 16'h0020, 16'h0000, 16'h0000, 0, 16'd5);
    vecs[15] = mk(0, 0, 16'h0000, 1,    1, 16'h0022, 16'h0020, 16'h1010, 0, 16'd5);
    vecs[16] = mk(1, 0, 16'h0000, 1,    1, 16'h0024, 16'h0022, 16'h1011, 0, 16'd6);
    vecs[17] = mk(0, 1, 16'h0006, 0,    0, 16'h0006, 16'h0000, 16'h0000, 0, 16'd6);
    vecs[18] = mk(0, 0, 16'h0000, 0,    0, 16'h0006, 16'h0000, 16'h0000, 1, 16'd6);
    vecs[19] = mk(1, 0, 16'h0000, 0,    0, 16'h0000, 16'h0000, 16'h0000, 0, 16'd6);
    vecs[20] = mk(0, 0, 16'h0000, 0,    1, 16'h0002, 16'h0000, 16'h1000, 0, 16'd6);
    vecs[21] = mk(0, 0, 16'h0000, 1,    1, 16'h0004, 16'h0002, 16'h1001, 0, 16'd7);

    drive(0, 0, 16'h0000, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ir_valid", 16'(m_if.ir_valid), 16'h0);
    chk("reset pc", m_if.pc, 16'h0000);
    chk("reset ir_instr", m_if.ir_instr, 16'h0000);
    chk("reset ir_pc", m_if.ir_pc, 16'h0000);
    chk("reset halted", 16'(m_halted), 16'h0);
    chk("reset fault", 16'(m_fault), 16'h0);
    chk("reset fetch_count", m_cnt, 16'h0000);
    rst_n = 1'b1;
    step();
    chk("idle no fetch pc", m_if.pc, 16'h0000);
    chk("idle no fetch valid", 16'(m_if.ir_valid), 16'h0);

    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].start, vecs[i].rv, vecs[i].rt, vecs[i].rdy);
      step();
      chk($sformatf("row%0d ir_valid", i), 16'(m_if.ir_valid), 16'(vecs[i].ev));
      chk($sformatf("row%0d pc", i), m_if.pc, vecs[i].epc);
      chk($sformatf("row%0d halted", i), 16'(m_halted), 16'(vecs[i].eh));
      chk($sformatf("row%0d fetch_count", i), m_cnt, vecs[i].ecnt);
      if (vecs[i].ev) begin
        chk($sformatf("row%0d ir_pc", i), m_if.ir_pc, vecs[i].eirpc);
        chk($sformatf("row%0d ir_instr", i), m_if.ir_instr, vecs[i].einstr);
      end
    end

    // Asynchronous reset while a word is held in the IR.
    drive(0, 0, 16'h0000, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst ir_valid", 16'(m_if.ir_valid), 16'h0);
    chk("async rst pc", m_if.pc, 16'h0000);
    chk("async rst fetch_count", m_cnt, 16'h0000);
    chk("async rst halted", 16'(m_halted), 16'h0);
    rst_n = 1'b1;
    drive(0, 0, 16'h0000, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post rst idle%0d pc", i), m_if.pc, 16'h0000);
      chk($sformatf("post rst idle%0d valid", i), 16'(m_if.ir_valid), 16'h0);
    end

    // Wrap at the top of the address space, and zero word delivered when HALT_ON_ZERO=0.
    drive(1, 0, 16'h0000, 1);
    step();
    drive(0, 1, 16'hFFFE, 1);
    step();
    chk("wrap redirect pc", z_if.pc, 16'hFFFE);
    chk("wrap redirect valid", 16'(z_if.ir_valid), 16'h0);
    drive(0, 0, 16'h0000, 1);
    step();
    chk("wrap ir_pc FFFE", z_if.ir_pc, 16'hFFFE);
    chk("wrap ir_instr FFFE", z_if.ir_instr, 16'h107F);
    chk("wrap pc 0000", z_if.pc, 16'h0000);
    step();
    chk("wrap ir_pc 0000", z_if.ir_pc, 16'h0000);
    chk("wrap ir_instr 0000", z_if.ir_instr, 16'h1000);
    chk("wrap pc 0002", z_if.pc, 16'h0002);
    step();
    step();
    step();
    chk("nz zero word valid", 16'(z_if.ir_valid), 16'h1);
    chk("nz zero word ir_pc", z_if.ir_pc, 16'h0006);
    chk("nz zero word instr", z_if.ir_instr, 16'h0000);
    chk("nz not halted", 16'(z_halted), 16'h0);
    chk("nz pc past zero", z_if.pc, 16'h0008);
    chk("main halted on zero", 16'(m_halted), 16'h1);
    chk("main halt pc", m_if.pc, 16'h0006);
    chk("main halt count", m_cnt, 16'd4);
    step();
    chk("nz zero word counted", z_cnt, 16'd5);
    chk("nz next ir_pc", z_if.ir_pc, 16'h0008);
    chk("nz next ir_instr", z_if.ir_instr, 16'h1004);

    // Misaligned redirect.
    drive(1, 0, 16'h0000, 1);
    step();
    chk("restart pc", m_if.pc, 16'h0000);
    drive(0, 1, 16'h0005, 1);
    step();
    chk("misalign valid", 16'(m_if.ir_valid), 16'h0);
`ifdef ALIGN_FAULT_EN
    chk("misalign fault", 16'(m_fault), 16'h1);
    chk("misalign pc held", m_if.pc, 16'h0000);
    drive(1, 0, 16'h0000, 1);
    step();
    chk("fault start ignored", 16'(m_fault), 16'h1);
    chk("fault valid", 16'(m_if.ir_valid), 16'h0);
    chk("fault pc", m_if.pc, 16'h0000);
`else
    chk("misalign fault", 16'(m_fault), 16'h0);
    chk("misalign pc forced even", m_if.pc, 16'h0004);
    drive(1, 0, 16'h0000, 1);
    step();
    chk("misalign next ir_pc", m_if.ir_pc, 16'h0004);
    chk("misalign next ir_instr", m_if.ir_instr, 16'h1002);
    chk("misalign next pc", m_if.pc, 16'h0006);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
